// File: rtl/ysyx_24070016_mem_arb.sv
// ysyx_24070016_mem_arb: shares a single memory port between the IFU (port 0)
// and the LSU (port 1). One transaction in flight at a time; a watchdog aborts
// a transaction that stays in REQ+RSP for TIMEOUT_CYC cycles.
//
// Configuration macro: YSYX_24070016_MEM_ARB_RR_EN
//   defined   -> round-robin arbitration between IFU and LSU
//   undefined -> fixed priority, LSU wins
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr                        fetch request
//   ifu_rsp_valid, ifu_rdata, ifu_rsp_err                fetch response
//   lsu_req_valid/ready, lsu_addr, lsu_wen/wdata/wmask   load/store request
//   lsu_rsp_valid, lsu_rdata, lsu_rsp_err                load/store response
//   mem_req_valid/ready, mem_addr, mem_wen/wdata/wmask   memory request
//   mem_rsp_valid, mem_rdata                             memory response
//   busy                         a transaction is in flight
module ysyx_24070016_mem_arb #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic        OWN_IFU = 1'b0;
    localparam logic        OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t           state;
    logic             owner;
    logic [CNT_W-1:0] tmo_cnt;
    logic             grant_lsu;
    logic             grant_ifu;
    logic             accept;
    logic             tmo_hit;

`ifdef YSYX_24070016_MEM_ARB_RR_EN
    logic             last_grant;
`endif

    // Arbitration: LSU wins a contested cycle unless round-robin says it had the last grant
    always_comb begin
        grant_lsu = 1'b0;
        grant_ifu = 1'b0;
`ifdef YSYX_24070016_MEM_ARB_RR_EN
        grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant == OWN_IFU));
`else
        grant_lsu = lsu_req_valid;
`endif
        grant_ifu = ifu_req_valid && !grant_lsu;
    end

    // Ready is gated by reset so every output reads 0 while rst is held
    assign accept        = (state == IDLE) && (ifu_req_valid || lsu_req_valid);
    assign ifu_req_ready = !rst && (state == IDLE) && grant_ifu;
    assign lsu_req_ready = !rst && (state == IDLE) && grant_lsu;

    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE);
    assign tmo_hit       = (TIMEOUT_CYC != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYC));

    // Transaction FSM with registered responses and latched request payload
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IFU;
            tmo_cnt       <= '0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_err   <= 1'b0;
            ifu_rdata     <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_err   <= 1'b0;
            lsu_rdata     <= '0;
`ifdef YSYX_24070016_MEM_ARB_RR_EN
            last_grant    <= OWN_IFU;
`endif
        end else begin
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (accept) begin
                        owner     <= grant_lsu ? OWN_LSU : OWN_IFU;
                        mem_addr  <= grant_lsu ? lsu_addr : ifu_addr;
                        mem_wen   <= grant_lsu && lsu_wen;
                        mem_wdata <= grant_lsu ? lsu_wdata : '0;
                        mem_wmask <= grant_lsu ? lsu_wmask : MASK_W'(0);
                        state     <= REQ;
`ifdef YSYX_24070016_MEM_ARB_RR_EN
                        last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
`endif
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (tmo_hit) begin
                        // Abort: error response with zero data to the owner
                        state   <= IDLE;
                        tmo_cnt <= '0;
                        if (owner == OWN_LSU) begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_err   <= 1'b1;
                            lsu_rdata     <= '0;
                        end else begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_err   <= 1'b1;
                            ifu_rdata     <= '0;
                        end
                    end else if (mem_req_ready) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    // A response in the same cycle as the timeout takes precedence
                    if (mem_rsp_valid) begin
                        state   <= IDLE;
                        tmo_cnt <= '0;
                        if (owner == OWN_LSU) begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rdata     <= mem_rdata;
                        end else begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rdata     <= mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        tmo_cnt <= '0;
                        if (owner == OWN_LSU) begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_err   <= 1'b1;
                            lsu_rdata     <= '0;
                        end else begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_err   <= 1'b1;
                            ifu_rdata     <= '0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule
